// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package bp_pkg;

  typedef logic [1:0] sat2_t;

  localparam sat2_t SAT2_RESET = 2'b01;
  localparam sat2_t SAT2_MAX   = 2'b11;
  localparam sat2_t SAT2_MIN   = 2'b00;

  // Tags are stored zero-extended to the widest possible tag so the entry type
  // does not depend on the predictor's INDEX_BITS parameter.
  localparam int TAG_MAX_BITS = 30;

  typedef struct packed {
    logic                    valid;
    logic [TAG_MAX_BITS-1:0] tag;
    logic [31:0]             target;
  } btb_entry_t;

  function automatic sat2_t sat2_next(sat2_t cnt, logic taken);
    sat2_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != SAT2_MAX) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SAT2_MIN) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one write port,
// valid bits cleared by asynchronous reset, tag/target storage left unreset.
module bp_btb
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_BITS-1:0]   rd_index,
  output logic                    rd_valid,
  output logic [TAG_MAX_BITS-1:0] rd_tag,
  output logic [31:0]             rd_target,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_index,
  input  logic                    wr_valid,
  input  logic [TAG_MAX_BITS-1:0] wr_tag,
  input  logic [31:0]             wr_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]      valid_mem;
  logic [TAG_MAX_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]             target_mem [ENTRIES];

  // Reads come straight from the registers, so a same-cycle write is seen next cycle.
  assign rd_valid  = valid_mem[rd_index];
  assign rd_tag    = tag_mem[rd_index];
  assign rd_target = target_mem[rd_index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem <= '0;
    end else if (wr_en) begin
      valid_mem[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]    <= wr_tag;
      target_mem[wr_index] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB + 2-bit PHT predictor with decode-stage miss detection and training.
// Define BP_GSHARE_EN to XOR a global history register into the PHT index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        predict_taken_f,
  output logic [31:0] predict_pc_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic [31:0] pc_d,
  input  logic [1:0]  branch_d,
  input  logic        pc_src_d,
  input  logic [31:0] branch_target_d,
  output logic        predict_miss,
  output logic [31:0] recover_pc_d
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  if (GHR_BITS < 2 || GHR_BITS > INDEX_BITS) begin : g_bad_ghr
    $error("branch_predictor: GHR_BITS must lie in [2, INDEX_BITS]");
  end

  logic [INDEX_BITS-1:0]   index_f;
  logic [INDEX_BITS-1:0]   pht_index_f;
  logic [INDEX_BITS-1:0]   index_d;
  logic [INDEX_BITS-1:0]   pht_index_d;
  logic [TAG_MAX_BITS-1:0] tag_f;
  logic [TAG_MAX_BITS-1:0] tag_d;
  btb_entry_t              btb_rd;
  logic                    btb_rd_valid;
  logic [TAG_MAX_BITS-1:0] btb_rd_tag;
  logic [31:0]             btb_rd_target;
  logic                    btb_hit_f;
  logic                    taken_d;
  logic [31:0]             target_d;
  logic                    update_d;
  logic                    scrub_d;
  logic                    btb_wr_en;
  sat2_t                   pht [ENTRIES];

  assign index_f = pc_f[INDEX_BITS+1:2];
  assign tag_f   = TAG_MAX_BITS'(pc_f[31:INDEX_BITS+2]);
  assign tag_d   = TAG_MAX_BITS'(pc_d[31:INDEX_BITS+2]);

  assign update_d  = !stall_d && (branch_d != 2'b00);
  assign scrub_d   = !stall_d && (branch_d == 2'b00) && taken_d;
  assign btb_wr_en = (update_d && pc_src_d) || scrub_d;

  bp_btb #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (index_f),
    .rd_valid  (btb_rd_valid),
    .rd_tag    (btb_rd_tag),
    .rd_target (btb_rd_target),
    .wr_en     (btb_wr_en),
    .wr_index  (index_d),
    .wr_valid  (!scrub_d),
    .wr_tag    (tag_d),
    .wr_target (branch_target_d)
  );

  assign btb_rd          = {btb_rd_valid, btb_rd_tag, btb_rd_target};
  assign btb_hit_f       = btb_rd.valid && (btb_rd.tag == tag_f);
  assign predict_taken_f = btb_hit_f && pht[pht_index_f][1];
  assign predict_pc_f    = predict_taken_f ? btb_rd.target : pc_f + 32'd4;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign pht_index_f = index_f ^ INDEX_BITS'(ghr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (update_d) begin
      ghr <= {ghr[GHR_BITS-2:0], pc_src_d};
    end
  end

  // The PHT index differs from the BTB index here, so it travels to D separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pht_index_d <= '0;
    end else if (flush_d) begin
      pht_index_d <= '0;
    end else if (!stall_d) begin
      pht_index_d <= pht_index_f;
    end
  end
`else
  assign pht_index_f = index_f;
  assign pht_index_d = index_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_d  <= 1'b0;
      target_d <= '0;
      index_d  <= '0;
    end else if (flush_d) begin
      taken_d  <= 1'b0;
      target_d <= '0;
      index_d  <= '0;
    end else if (!stall_d) begin
      taken_d  <= predict_taken_f;
      target_d <= btb_rd.target;
      index_d  <= index_f;
    end
  end

  // Training uses the fetch-time index and still happens when D is being flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= SAT2_RESET;
    end else if (update_d) begin
      pht[pht_index_d] <= sat2_next(pht[pht_index_d], pc_src_d);
    end
  end

  assign predict_miss = !stall_d && (
                          ((branch_d != 2'b00) && (pc_src_d != taken_d))
                       || ((branch_d != 2'b00) && pc_src_d && taken_d && (target_d != branch_target_d))
                       || ((branch_d == 2'b00) && taken_d));

  assign recover_pc_d = pc_src_d ? branch_target_d : pc_d + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table-driven vectors through a scoreboard
// queue, plus hand-written async-reset and history-pattern sequences.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        predict_taken_f;
  logic [31:0] predict_pc_f;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] pc_d;
  logic [1:0]  branch_d;
  logic        pc_src_d;
  logic [31:0] branch_target_d;
  logic        predict_miss;
  logic [31:0] recover_pc_d;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc_f;
    logic        stall;
    logic        flush;
    logic [1:0]  br;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] pcd;
    logic        e_taken;
    logic [31:0] e_pc;
    logic        e_miss;
    logic [31:0] e_rec;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic        miss;
    logic [31:0] rec;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_f            (pc_f),
    .predict_taken_f (predict_taken_f),
    .predict_pc_f    (predict_pc_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .pc_d            (pc_d),
    .branch_d        (branch_d),
    .pc_src_d        (pc_src_d),
    .branch_target_d (branch_target_d),
    .predict_miss    (predict_miss),
    .recover_pc_d    (recover_pc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [31:0] pf, logic st, logic fl, logic [1:0] br, logic src,
                              logic [31:0] tgt, logic [31:0] pcd, logic etk, logic [31:0] epc,
                              logic emiss, logic [31:0] erec);
    vec_t v;
    v.pc_f = pf; v.stall = st; v.flush = fl; v.br = br; v.src = src; v.tgt = tgt; v.pcd = pcd;
    v.e_taken = etk; v.e_pc = epc; v.e_miss = emiss; v.e_rec = erec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(logic [31:0] pf, logic st, logic fl, logic [1:0] br, logic src,
                       logic [31:0] tgt, logic [31:0] pcd);
    pc_f = pf; stall_d = st; flush_d = fl; branch_d = br; pc_src_d = src;
    branch_target_d = tgt; pc_d = pcd;
  endtask

  task automatic applyStimulus(vec_t v);
    exp_t e;
    drive(v.pc_f, v.stall, v.flush, v.br, v.src, v.tgt, v.pcd);
    e.taken = v.e_taken; e.pc = v.e_pc; e.miss = v.e_miss; e.rec = v.e_rec;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL v%0d_scoreboard: got empty queue expected an entry", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d_taken_f", idx), {31'd0, predict_taken_f}, {31'd0, e.taken});
      check($sformatf("v%0d_pc_f", idx), predict_pc_f, e.pc);
      check($sformatf("v%0d_miss", idx), {31'd0, predict_miss}, {31'd0, e.miss});
      check($sformatf("v%0d_recover", idx), recover_pc_d, e.rec);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(32'h100, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Alternating taken/not-taken branch at 0x100, each resolved with no pipeline overlap.
  task automatic run_history_pattern();
    int late_misses;
    int expected_late;
    late_misses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(32'h100, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      drive(32'h804, 1'b0, 1'b0, 2'd1, (i % 2 == 0), 32'h200, 32'h100);
      #1;
      if (i >= 8 && predict_miss) late_misses++;
    end
`ifdef BP_GSHARE_EN
    expected_late = 0;
`else
    expected_late = 4;
`endif
    check("history_late_misses", late_misses, expected_late);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_dut();
    #1;
    check("reset_taken_f", {31'd0, predict_taken_f}, 32'd0);
    check("reset_pc_f", predict_pc_f, 32'h104);
    check("reset_miss", {31'd0, predict_miss}, 32'd0);

`ifndef BP_GSHARE_EN
    // pc_f, stall, flush, branch, src, target, pc_d -> taken_f, pc_f', miss, recover
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 0, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 0, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 0, 32'h200, 32'h100, 0, 32'h808, 1, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 0, 32'h200, 32'h100, 0, 32'h808, 1, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(32'h804, 1, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 0, 32'h200));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 0, 32'h200, 32'h100, 0, 32'h808, 1, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h100, 0, 1, 2'd1, 1, 32'h200, 32'h100, 1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 1, 1, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 0, 32'h200));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h200, 32'h100, 0, 32'h808, 1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 1, 0, 2'd0, 0, 32'h0,   32'h0,   0, 32'h808, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd2, 1, 32'h200, 32'h100, 0, 32'h808, 0, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h200, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd3, 1, 32'h300, 32'h100, 0, 32'h808, 1, 32'h300));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4));
    vecs.push_back(mk(32'h200, 0, 0, 2'd1, 1, 32'h300, 32'h100, 0, 32'h204, 0, 32'h300));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd0, 0, 32'h0,   32'h100, 0, 32'h808, 1, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   0, 32'h104, 0, 32'h4));
    vecs.push_back(mk(32'h804, 0, 0, 2'd1, 1, 32'h300, 32'h100, 0, 32'h808, 1, 32'h300));
    vecs.push_back(mk(32'h100, 0, 0, 2'd0, 0, 32'h0,   32'h0,   1, 32'h300, 0, 32'h4));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i);
    end
`endif

    // Asynchronous reset in the middle of a cycle wipes BTB and history at once.
    @(negedge clk);
    drive(32'h100, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_taken_f", {31'd0, predict_taken_f}, 32'd0);
    check("async_reset_pc_f", predict_pc_f, 32'h104);
    check("async_reset_miss", {31'd0, predict_miss}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    reset_dut();
    run_history_pattern();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
